// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// bit_serializer
//   Parallel-to-serial stage. A WIDTH-bit word is accepted over a valid/ready
//   handshake and driven one bit per clock on serial_out. serial_valid marks
//   each live bit. done marks the cycle that carries the last bit of a word.
//   A new word can be accepted during the last-bit cycle, so words follow each
//   other with no idle gap. pause freezes shifting while a word is in flight.
//
// Ports
//   clock        in   1      rising-edge clock for all state
//   reset        in   1      synchronous, active-low clear
//   load_data    in   WIDTH  word to serialise
//   load_valid   in   1      load_data is valid
//   load_ready   out  1      combinational; accept = load_valid && load_ready
//   pause        in   1      hold the current bit, stop advancing
//   serial_out   out  1      serial bit stream (registered)
//   serial_valid out  1      serial_out carries a live bit (registered)
//   done         out  1      last bit of a word is on serial_out (registered)
// ---------------------------------------------------------------------------
module bit_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             pause,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             done
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             serial_out_q, serial_out_d;
    logic             serial_valid_q, serial_valid_d;
    logic             done_q, done_d;

    logic             last_bit;
    logic             accept;

    // Bit that leaves the word next, depending on the shift direction.
    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Word with its head bit consumed.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // The last bit is on the line and will be retired at the coming edge,
    // which is the only point in a word where a new one may be taken.
    assign last_bit   = (state_q == SHIFT) && (cnt_q == LAST) && !pause;
    assign load_ready = reset && ((state_q == IDLE) || last_bit);
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        cnt_d          = cnt_q;
        serial_out_d   = serial_out_q;
        serial_valid_d = serial_valid_q;
        done_d         = done_q;

        if (accept) begin
            // First bit goes straight to the output register; the remainder
            // waits in the shift register. WIDTH >= 2, so never done here.
            state_d        = SHIFT;
            cnt_d          = '0;
            serial_out_d   = head(load_data);
            shift_d        = advance(load_data);
            serial_valid_d = 1'b1;
            done_d         = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    serial_out_d   = IDLE_LEVEL;
                    serial_valid_d = 1'b0;
                    done_d         = 1'b0;
                end
                SHIFT: begin
                    if (pause) begin
                        // Bit, count and done hold; only the qualifier drops.
                        serial_valid_d = 1'b0;
                    end else if (cnt_q == LAST) begin
                        state_d        = IDLE;
                        cnt_d          = '0;
                        serial_out_d   = IDLE_LEVEL;
                        serial_valid_d = 1'b0;
                        done_d         = 1'b0;
                    end else begin
                        cnt_d          = cnt_q + CW'(1);
                        serial_out_d   = head(shift_q);
                        shift_d        = advance(shift_q);
                        serial_valid_d = 1'b1;
                        done_d         = ((cnt_q + CW'(1)) == LAST);
                    end
                end
                default: begin
                    state_d        = IDLE;
                    serial_out_d   = IDLE_LEVEL;
                    serial_valid_d = 1'b0;
                    done_d         = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= IDLE;
            shift_q        <= '0;
            cnt_q          <= '0;
            serial_out_q   <= IDLE_LEVEL;
            serial_valid_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            cnt_q          <= cnt_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
            done_q         <= done_d;
        end
    end

    assign serial_out   = serial_out_q;
    assign serial_valid = serial_valid_q;
    assign done         = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// ---------------------------------------------------------------------------
// tb_bit_serializer
//   Directed, table-driven bench for bit_serializer (WIDTH=8). The MSB-first
//   instance runs a per-cycle vector table; an LSB-first instance is driven by
//   a short hand-written sequence.
// ---------------------------------------------------------------------------
module tb_bit_serializer;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] load_data;
    logic       load_valid;
    logic       pause;
    logic       load_ready, serial_out, serial_valid, done;

    logic [7:0] l_load_data;
    logic       l_load_valid;
    logic       l_pause;
    logic       l_load_ready, l_serial_out, l_serial_valid, l_done;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clock = ~clock;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
        .clock       (clock),
        .reset       (reset),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .pause       (pause),
        .serial_out  (serial_out),
        .serial_valid(serial_valid),
        .done        (done)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
        .clock       (clock),
        .reset       (reset),
        .load_data   (l_load_data),
        .load_valid  (l_load_valid),
        .load_ready  (l_load_ready),
        .pause       (l_pause),
        .serial_out  (l_serial_out),
        .serial_valid(l_serial_valid),
        .done        (l_done)
    );

    // One clock cycle: inputs applied during the cycle, expected load_ready
    // in that cycle, and expected registered outputs after the edge.
    typedef struct {
        logic       rst;
        logic       lv;
        logic [7:0] ld;
        logic       pz;
        logic       rdy;
        logic       so;
        logic       sv;
        logic       dn;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic lv, input logic [7:0] ld,
                                input logic pz, input logic rdy, input logic so,
                                input logic sv, input logic dn);
        vec_t v;
        v.rst = rst; v.lv = lv; v.ld = ld; v.pz = pz;
        v.rdy = rdy; v.so = so; v.sv = sv; v.dn = dn;
        vecs.push_back(v);
    endfunction

    // Full word, MSB first, starting from a cycle where load_ready is 1.
    // Middle cycles drive load_valid=mid_lv with the inverted word, which
    // must be ignored.
    function automatic void add_word(input logic [7:0] w, input logic mid_lv,
                                     input logic acc_pause);
        add(1'b1, 1'b1, w, acc_pause, 1'b1, w[7], 1'b1, 1'b0);
        for (int i = 1; i < 8; i++)
            add(1'b1, mid_lv, ~w, 1'b0, 1'b0, w[7-i], 1'b1, (i == 7));
    endfunction

    task automatic chk(input string nm, input int idx, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %b expected %b", nm, idx, act, exp);
        end
    endtask

    initial begin
        reset        = 1'b0;
        load_data    = '0;
        load_valid   = 1'b0;
        pause        = 1'b0;
        l_load_data  = '0;
        l_load_valid = 1'b0;
        l_pause      = 1'b0;

        // Reset: two cycles low, then released into IDLE.
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Single word 8'hE0, then back to idle.
        add_word(8'hE0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Back-to-back 8'hA5 then 8'h3C with load_valid held high.
        add_word(8'hA5, 1'b1, 1'b0);
        add_word(8'h3C, 1'b1, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // 8'hFF with a 3-cycle pause after bit 2, then a pause on the last bit.
        add(1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            add(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int b = 3; b <= 8; b++)
            add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, (b == 8));
        add(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // 8'hC3 abandoned by reset after bit 4; then 8'h81 accepted with
        // pause high in IDLE (no effect).
        add(1'b1, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_word(8'h81, 1'b0, 1'b1);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            reset      = vecs[i].rst;
            load_valid = vecs[i].lv;
            load_data  = vecs[i].ld;
            pause      = vecs[i].pz;
            #1;
            chk("load_ready", i, load_ready, vecs[i].rdy);
            @(posedge clock);
            #1;
            chk("serial_out", i, serial_out, vecs[i].so);
            chk("serial_valid", i, serial_valid, vecs[i].sv);
            chk("done", i, done, vecs[i].dn);
            $display("step %0d: rst=%b lv=%b data=%h pause=%b -> rdy=%b out=%b valid=%b done=%b",
                     i, vecs[i].rst, vecs[i].lv, vecs[i].ld, vecs[i].pz,
                     load_ready, serial_out, serial_valid, done);
        end

        // LSB-first instance: 8'h01 sends 1 then seven 0s; load_valid pulses
        // mid-word must see load_ready=0 and be ignored.
        load_valid   = 1'b0;
        pause        = 1'b0;
        reset        = 1'b1;
        l_load_data  = 8'h01;
        l_load_valid = 1'b1;
        #1;
        chk("lsb_ready_idle", 0, l_load_ready, 1'b1);
        @(posedge clock);
        #1;
        chk("lsb_out", 0, l_serial_out, 1'b1);
        chk("lsb_valid", 0, l_serial_valid, 1'b1);
        chk("lsb_done", 0, l_done, 1'b0);
        $display("lsb bit 1: out=%b valid=%b done=%b", l_serial_out, l_serial_valid, l_done);
        for (int b = 2; b <= 8; b++) begin
            l_load_valid = b[0];
            l_load_data  = 8'hFF;
            #1;
            chk("lsb_ready_mid", b, l_load_ready, 1'b0);
            @(posedge clock);
            #1;
            chk("lsb_out", b, l_serial_out, 1'b0);
            chk("lsb_valid", b, l_serial_valid, 1'b1);
            chk("lsb_done", b, l_done, (b == 8));
            $display("lsb bit %0d: out=%b valid=%b done=%b", b, l_serial_out, l_serial_valid, l_done);
        end
        l_load_valid = 1'b0;
        #1;
        chk("lsb_ready_last", 9, l_load_ready, 1'b1);
        @(posedge clock);
        #1;
        chk("lsb_valid_idle", 9, l_serial_valid, 1'b0);
        chk("lsb_done_idle", 9, l_done, 1'b0);
        $display("lsb idle: out=%b valid=%b done=%b", l_serial_out, l_serial_valid, l_done);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
